execute_mul_pipe: RTL and testbench

//  Pipelined integer multiply execute unit for RV32M MUL/MULH/MULHSU/MULHU.

---
 rtl/execute_mul_pipe_pkg.sv | 87 ++++++++
 rtl/execute_mul_core.sv | 101 ++++++++++
 rtl/execute_mul_pipe.sv | 169 ++++++++++++++++
 tb/tb_execute_mul_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_mul_pipe_pkg.sv
// execute_mul_pipe_pkg
//   Shared types and constants for the pipelined RV32M multiply execute unit.
//   Contents:
//     MUL_XLEN, MUL_PIPE_STAGES, MUL_PROD_W  - default width, depth, product width
//     mul_op_t                    - MUL / MULH / MULHSU / MULHU selector
//     issue_execute_pack_t        - op as delivered by the issue->mul FIFO
//     execute_wb_pack_t           - result pack handed to the writeback port
//     execute_feedback_channel_t  - wakeup/bypass channel
//     commit_feedback_pack_t      - commit-side flush request
//     mul_ctrl_t                  - per-stage control record (valid, op, pack)
//     mul_stage_t                 - last-stage view: control record plus product
package execute_mul_pipe_pkg;

  localparam int MUL_XLEN        = 32;
  localparam int MUL_PIPE_STAGES = 3;
  localparam int MUL_PROD_W      = 2 * MUL_XLEN + 2;
  localparam int ROB_ID_W        = 7;
  localparam int PHY_REG_ID_W    = 6;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHSU = 2'd2,
    MUL_OP_MULHU  = 2'd3
  } mul_op_t;

  typedef struct packed {
    logic                    enable;
    logic                    valid;
    logic [ROB_ID_W-1:0]     rob_id;
    logic [31:0]             pc;
    logic [31:0]             inst;
    logic [PHY_REG_ID_W-1:0] rd_phy;
    logic                    rd_enable;
    logic                    need_rename;
    logic                    has_exception;
    logic [3:0]              exception_id;
    logic [31:0]             exception_value;
    mul_op_t                 op;
    logic [MUL_XLEN-1:0]     src1;
    logic [MUL_XLEN-1:0]     src2;
  } issue_execute_pack_t;

  typedef struct packed {
    logic                    enable;
    logic                    valid;
    logic [ROB_ID_W-1:0]     rob_id;
    logic [31:0]             pc;
    logic [31:0]             inst;
    logic [PHY_REG_ID_W-1:0] rd_phy;
    logic                    rd_enable;
    logic                    need_rename;
    logic [MUL_XLEN-1:0]     rd_value;
    logic                    has_exception;
    logic [3:0]              exception_id;
    logic [31:0]             exception_value;
    logic                    bru_jump;
    logic [31:0]             bru_next_pc;
    logic [31:0]             csr_newvalue;
    logic                    csr_newvalue_valid;
  } execute_wb_pack_t;

  typedef struct packed {
    logic                    enable;
    logic [PHY_REG_ID_W-1:0] phy_id;
    logic [MUL_XLEN-1:0]     value;
  } execute_feedback_channel_t;

  typedef struct packed {
    logic enable;
    logic flush;
  } commit_feedback_pack_t;

  typedef struct packed {
    logic             valid;
    mul_op_t          op;
    execute_wb_pack_t pack;
  } mul_ctrl_t;

  typedef struct packed {
    logic                  valid;
    mul_op_t               op;
    execute_wb_pack_t      pack;
    logic [MUL_PROD_W-1:0] partial;
  } mul_stage_t;

endpackage

// File: rtl/execute_mul_core.sv
// execute_mul_core
//   Purely arithmetic staged multiplier. Operands are extended to XLEN+1 bits
//   according to the op, split into two partial products in stage 0, summed
//   into the full (2*XLEN+2)-bit product entering stage 1, then carried to the
//   last stage. All registers move only when advance is high.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     advance         shift the arithmetic pipeline by one stage
//     op, src1, src2  operation and operands entering stage 0
//     product         product of the op that sits in stage STAGES-1
module execute_mul_core
  import execute_mul_pipe_pkg::*;
#(
  parameter int XLEN   = MUL_XLEN,
  parameter int STAGES = MUL_PIPE_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  mul_op_t           op,
  input  logic [XLEN-1:0]   src1,
  input  logic [XLEN-1:0]   src2,
  output logic [2*XLEN+1:0] product
);

  localparam int PROD_W = 2 * XLEN + 2;
  localparam int LO_W   = XLEN / 2;
  localparam int HI_W   = XLEN - LO_W;

  logic              a_sign;
  logic              b_sign;
  logic [PROD_W-1:0] a_wide;
  logic [PROD_W-1:0] b_lo_wide;
  logic [PROD_W-1:0] b_hi_wide;
  logic [PROD_W-1:0] pp_lo_new;
  logic [PROD_W-1:0] pp_hi_new;
  logic [PROD_W-1:0] pp_lo_d;
  logic [PROD_W-1:0] pp_hi_d;
  logic [PROD_W-1:0] pp_lo_q;
  logic [PROD_W-1:0] pp_hi_q;
  logic [PROD_W-1:0] pp_sum;

  // Operands are carried at full product width so the modular product equals
  // the signed product of the (XLEN+1)-bit extended values. src2 is split into
  // an unsigned low half and a sign-carrying high half.
  always_comb begin
    a_sign    = (op != MUL_OP_MULHU) && src1[XLEN-1];
    b_sign    = ((op == MUL_OP_MUL) || (op == MUL_OP_MULH)) && src2[XLEN-1];
    a_wide    = {{(PROD_W-XLEN){a_sign}}, src1};
    b_lo_wide = {{(PROD_W-LO_W){1'b0}}, src2[LO_W-1:0]};
    b_hi_wide = {{(PROD_W-HI_W){b_sign}}, src2[XLEN-1:LO_W]};
    pp_lo_new = a_wide * b_lo_wide;
    pp_hi_new = a_wide * b_hi_wide;
    pp_lo_d   = advance ? pp_lo_new : pp_lo_q;
    pp_hi_d   = advance ? pp_hi_new : pp_hi_q;
    pp_sum    = pp_lo_q + (pp_hi_q << LO_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pp_lo_q <= '0;
      pp_hi_q <= '0;
    end else begin
      pp_lo_q <= pp_lo_d;
      pp_hi_q <= pp_hi_d;
    end
  end

  generate
    if (STAGES == 1) begin : g_single
      // Single-stage build: the sum is formed combinationally at the only stage.
      assign product = pp_sum;
    end else begin : g_multi
      logic [PROD_W-1:0] prod_q [1:STAGES-1];
      logic [PROD_W-1:0] prod_d [1:STAGES-1];

      always_comb begin
        prod_d = prod_q;
        if (advance) begin
          prod_d[1] = pp_sum;
          for (int i = 2; i < STAGES; i++) begin
            prod_d[i] = prod_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 1; i < STAGES; i++) begin
            prod_q[i] <= '0;
          end
        end else begin
          prod_q <= prod_d;
        end
      end

      assign product = prod_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/execute_mul_pipe.sv
// execute_mul_pipe
//   Pipelined RV32M multiply execute unit (MUL/MULH/MULHSU/MULHU) between the
//   issue->mul FIFO and the mul writeback port. Latency STAGES cycles from pop
//   to write, one op per cycle, whole-pipe stall on writeback back-pressure,
//   whole-pipe flush on a commit flush request.
//   Optional build macro: EXECUTE_MUL_EARLY_WAKEUP_EN adds mul_early_wakeup_pack,
//   a wakeup raised one cycle ahead of the regular feedback (needs STAGES >= 2).
//   Ports:
//     clk, rst                             clock, synchronous active-high reset
//     issue_mul_fifo_data_out[_valid]      FIFO head and its valid
//     issue_mul_fifo_pop                   pop FIFO head this cycle
//     mul_wb_port_data_in / _we / _flush   result pack, write strobe, flush
//     mul_wb_port_full                     writeback port cannot accept
//     mul_execute_channel_feedback_pack    result wakeup/bypass
//     commit_feedback_pack                 commit-side flush request
//     mul_early_wakeup_pack                (macro only) early wakeup, value 0
module execute_mul_pipe
  import execute_mul_pipe_pkg::*;
#(
  parameter int XLEN   = MUL_XLEN,
  parameter int STAGES = MUL_PIPE_STAGES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  issue_execute_pack_t       issue_mul_fifo_data_out,
  input  logic                      issue_mul_fifo_data_out_valid,
  output logic                      issue_mul_fifo_pop,
  output execute_wb_pack_t          mul_wb_port_data_in,
  output logic                      mul_wb_port_we,
  output logic                      mul_wb_port_flush,
  input  logic                      mul_wb_port_full,
  output execute_feedback_channel_t mul_execute_channel_feedback_pack,
  input  commit_feedback_pack_t     commit_feedback_pack
`ifdef EXECUTE_MUL_EARLY_WAKEUP_EN
  ,
  output execute_feedback_channel_t mul_early_wakeup_pack
`endif
);

  localparam int PROD_W = 2 * XLEN + 2;
  localparam int LAST   = STAGES - 1;

  mul_ctrl_t         stage_q [STAGES];
  mul_ctrl_t         stage_d [STAGES];
  logic              flush_req;
  logic              stall;
  logic              pop;
  logic              we;
  logic [PROD_W-1:0] product;
  mul_stage_t        last_stage;
  logic [XLEN-1:0]   rd_value;
  logic              unused_prod_sign;

  // The pop and write strobes are held low while rst is high so nothing is
  // consumed from the FIFO or retired during reset.
  always_comb begin
    flush_req = commit_feedback_pack.enable && commit_feedback_pack.flush;
    stall     = stage_q[LAST].valid && mul_wb_port_full && !flush_req;
    pop       = !rst && issue_mul_fifo_data_out_valid && !stall && !flush_req;
    we        = !rst && stage_q[LAST].valid && !mul_wb_port_full && !flush_req;
  end

  assign issue_mul_fifo_pop = pop;
  assign mul_wb_port_we     = we;
  assign mul_wb_port_flush  = flush_req;

  always_comb begin
    stage_d = stage_q;
    if (flush_req) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_d[i].valid = 1'b0;
      end
    end else if (!stall) begin
      for (int i = LAST; i > 0; i--) begin
        stage_d[i] = stage_q[i-1];
      end
      stage_d[0].valid                   = pop;
      stage_d[0].op                      = issue_mul_fifo_data_out.op;
      stage_d[0].pack                    = '0;
      stage_d[0].pack.enable             = issue_mul_fifo_data_out.enable;
      stage_d[0].pack.valid              = issue_mul_fifo_data_out.valid;
      stage_d[0].pack.rob_id             = issue_mul_fifo_data_out.rob_id;
      stage_d[0].pack.pc                 = issue_mul_fifo_data_out.pc;
      stage_d[0].pack.inst               = issue_mul_fifo_data_out.inst;
      stage_d[0].pack.rd_phy             = issue_mul_fifo_data_out.rd_phy;
      stage_d[0].pack.rd_enable          = issue_mul_fifo_data_out.rd_enable;
      stage_d[0].pack.need_rename        = issue_mul_fifo_data_out.need_rename;
      stage_d[0].pack.has_exception      = issue_mul_fifo_data_out.has_exception;
      stage_d[0].pack.exception_id       = issue_mul_fifo_data_out.exception_id;
      stage_d[0].pack.exception_value    = issue_mul_fifo_data_out.exception_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  // The arithmetic pipeline shifts in lock-step with the control stages; its
  // stage-0 load of a non-popped head is harmless because valid stays 0.
  execute_mul_core #(
    .XLEN   (XLEN),
    .STAGES (STAGES)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .advance (!stall),
    .op      (issue_mul_fifo_data_out.op),
    .src1    (issue_mul_fifo_data_out.src1),
    .src2    (issue_mul_fifo_data_out.src2),
    .product (product)
  );

  always_comb begin
    last_stage.valid   = stage_q[LAST].valid;
    last_stage.op      = stage_q[LAST].op;
    last_stage.pack    = stage_q[LAST].pack;
    last_stage.partial = product;

    unique case (last_stage.op)
      MUL_OP_MUL: rd_value = last_stage.partial[XLEN-1:0];
      default:    rd_value = last_stage.partial[2*XLEN-1:XLEN];
    endcase
    if (last_stage.pack.has_exception) begin
      rd_value = '0;
    end

    mul_wb_port_data_in          = last_stage.pack;
    mul_wb_port_data_in.rd_value = rd_value;

    mul_execute_channel_feedback_pack.enable = we
                                               && last_stage.pack.enable
                                               && last_stage.pack.valid
                                               && last_stage.pack.rd_enable
                                               && last_stage.pack.need_rename
                                               && !last_stage.pack.has_exception;
    mul_execute_channel_feedback_pack.phy_id = last_stage.pack.rd_phy;
    mul_execute_channel_feedback_pack.value  = rd_value;
  end

  // Top two product bits only matter for the signed extension inside the core.
  assign unused_prod_sign = ^product[PROD_W-1:2*XLEN];

`ifdef EXECUTE_MUL_EARLY_WAKEUP_EN
  generate
    if (STAGES >= 2) begin : g_early
      always_comb begin
        mul_early_wakeup_pack.enable = !rst && !stall && !flush_req
                                       && stage_q[STAGES-2].valid
                                       && stage_q[STAGES-2].pack.enable
                                       && stage_q[STAGES-2].pack.valid
                                       && stage_q[STAGES-2].pack.rd_enable
                                       && stage_q[STAGES-2].pack.need_rename
                                       && !stage_q[STAGES-2].pack.has_exception;
        mul_early_wakeup_pack.phy_id = stage_q[STAGES-2].pack.rd_phy;
        mul_early_wakeup_pack.value  = '0;
      end
    end else begin : g_no_early
      assign mul_early_wakeup_pack = '0;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_execute_mul_pipe.sv
module tb_execute_mul_pipe;
  import execute_mul_pipe_pkg::*;

  localparam int STAGES = MUL_PIPE_STAGES;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  issue_execute_pack_t       fifo_data;
  logic                      fifo_valid;
  logic                      pop;
  execute_wb_pack_t          wb_data;
  logic                      we;
  logic                      wb_flush;
  logic                      wb_full;
  execute_feedback_channel_t fb;
  commit_feedback_pack_t     commit_fb;
`ifdef EXECUTE_MUL_EARLY_WAKEUP_EN
  execute_feedback_channel_t early_fb;
`endif

  always #5 clk = ~clk;

  execute_mul_pipe #(
    .XLEN   (MUL_XLEN),
    .STAGES (STAGES)
  ) dut (
    .clk                               (clk),
    .rst                               (rst),
    .issue_mul_fifo_data_out           (fifo_data),
    .issue_mul_fifo_data_out_valid     (fifo_valid),
    .issue_mul_fifo_pop                (pop),
    .mul_wb_port_data_in               (wb_data),
    .mul_wb_port_we                    (we),
    .mul_wb_port_flush                 (wb_flush),
    .mul_wb_port_full                  (wb_full),
    .mul_execute_channel_feedback_pack (fb),
    .commit_feedback_pack              (commit_fb)
`ifdef EXECUTE_MUL_EARLY_WAKEUP_EN
    ,
    .mul_early_wakeup_pack             (early_fb)
`endif
  );

  typedef struct {
    issue_execute_pack_t p;
    int                  pop_cyc;
    int                  pos;
    int                  stalls;
    bit                  has_gold;
    logic [31:0]         gold;
  } ent_t;

  ent_t src_q[$];
  ent_t fly_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   we_cnt = 0;
  int   we_first = 0;
  int   we_last = 0;
  logic rst_r = 1'b1;
  logic full_r = 1'b0;
  logic cen_r = 1'b0;
  logic flush_r = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the ISA definition using 64-bit integers.
  function automatic logic [31:0] ref_mul(input mul_op_t op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      MUL_OP_MUL:    r = sa * sb;
      MUL_OP_MULH:   r = sa * sb;
      MUL_OP_MULHSU: r = sa * longint'(ub);
      default:       r = ua * ub;
    endcase
    return (op == MUL_OP_MUL) ? r[31:0] : r[63:32];
  endfunction

  function automatic bit wakes(input issue_execute_pack_t p);
    return p.enable && p.valid && p.rd_enable && p.need_rename && !p.has_exception;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic push_op(input mul_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input bit exc, input bit has_gold, input logic [31:0] gold);
    ent_t e;
    e.p                 = '0;
    e.p.enable          = 1'b1;
    e.p.valid           = 1'b1;
    e.p.rob_id          = 7'($urandom);
    e.p.pc              = $urandom;
    e.p.inst            = $urandom;
    e.p.rd_phy          = 6'($urandom);
    e.p.rd_enable       = ($urandom_range(0, 7) != 0);
    e.p.need_rename     = ($urandom_range(0, 7) != 0);
    e.p.has_exception   = exc;
    e.p.exception_id    = exc ? 4'($urandom) : 4'h0;
    e.p.exception_value = exc ? $urandom : 32'h0;
    e.p.op              = op;
    e.p.src1            = a;
    e.p.src2            = b;
    e.pop_cyc           = 0;
    e.pos               = 0;
    e.stalls            = 0;
    e.has_gold          = has_gold;
    e.gold              = gold;
    src_q.push_back(e);
  endtask

  task automatic push_rand();
    push_op(mul_op_t'($urandom_range(0, 3)), pick_operand(), pick_operand(),
            ($urandom_range(0, 15) == 0), 1'b0, 32'h0);
  endtask

  // One clock: drive at negedge, check outputs before the rising edge, then
  // advance the reference model by what should have happened on that edge.
  task automatic step();
    bit          flush_e;
    bit          last_e;
    bit          stall_e;
    bit          pop_e;
    bit          we_e;
    bit          fbe_e;
    ent_t        e;
    logic [31:0] exp_val;
`ifdef EXECUTE_MUL_EARLY_WAKEUP_EN
    bit          ewe_e;
`endif
    @(negedge clk);
    rst              = rst_r;
    wb_full          = full_r;
    commit_fb.enable = cen_r;
    commit_fb.flush  = flush_r;
    fifo_valid       = (src_q.size() > 0);
    fifo_data        = fifo_valid ? src_q[0].p : '0;
    #1;
    flush_e = cen_r && flush_r;
    last_e  = (fly_q.size() > 0) && (fly_q[0].pos == STAGES - 1);
    stall_e = last_e && full_r && !flush_e;
    pop_e   = !rst_r && fifo_valid && !stall_e && !flush_e;
    we_e    = !rst_r && last_e && !full_r && !flush_e;
    check_eq("pop", 64'(pop), 64'(pop_e));
    check_eq("we", 64'(we), 64'(we_e));
    check_eq("wb_flush", 64'(wb_flush), 64'(flush_e));
    fbe_e = 1'b0;
    if (we_e) begin
      e       = fly_q[0];
      exp_val = e.p.has_exception ? 32'h0 : ref_mul(e.p.op, e.p.src1, e.p.src2);
      fbe_e   = wakes(e.p);
      check_eq("rd_value", 64'(wb_data.rd_value), 64'(exp_val));
      if (e.has_gold) check_eq("rd_value_golden", 64'(wb_data.rd_value), 64'(e.gold));
      check_eq("rob_id", 64'(wb_data.rob_id), 64'(e.p.rob_id));
      check_eq("pc", 64'(wb_data.pc), 64'(e.p.pc));
      check_eq("rd_phy", 64'(wb_data.rd_phy), 64'(e.p.rd_phy));
      check_eq("exc_fields", 64'({wb_data.has_exception, wb_data.exception_id}),
               64'({e.p.has_exception, e.p.exception_id}));
      check_eq("bru_csr_zero", 64'({wb_data.bru_jump, wb_data.csr_newvalue_valid,
                                    wb_data.bru_next_pc | wb_data.csr_newvalue}), 64'(0));
      check_eq("latency", 64'(cyc - e.pop_cyc), 64'(STAGES + e.stalls));
      if (fbe_e) begin
        check_eq("fb_value", 64'(fb.value), 64'(exp_val));
        check_eq("fb_phy", 64'(fb.phy_id), 64'(e.p.rd_phy));
      end
    end
    check_eq("fb_enable", 64'(fb.enable), 64'(fbe_e));
`ifdef EXECUTE_MUL_EARLY_WAKEUP_EN
    ewe_e = 1'b0;
    foreach (fly_q[i]) begin
      if (fly_q[i].pos == STAGES - 2 && wakes(fly_q[i].p))
        ewe_e = !rst_r && !stall_e && !flush_e;
    end
    check_eq("early_enable", 64'(early_fb.enable), 64'(ewe_e));
`endif
    if (we) begin
      if (we_cnt == 0) we_first = cyc;
      we_last = cyc;
      we_cnt++;
    end
    @(posedge clk);
    if (rst_r || flush_e) begin
      fly_q.delete();
    end else if (stall_e) begin
      foreach (fly_q[i]) fly_q[i].stalls++;
    end else begin
      if (last_e) void'(fly_q.pop_front());
      foreach (fly_q[i]) fly_q[i].pos++;
      if (pop_e) begin
        e         = src_q.pop_front();
        e.pop_cyc = cyc;
        e.pos     = 0;
        e.stalls  = 0;
        fly_q.push_back(e);
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    fifo_valid       = 1'b0;
    fifo_data        = '0;
    wb_full          = 1'b0;
    commit_fb.enable = 1'b0;
    commit_fb.flush  = 1'b0;

    // Reset, with a FIFO head already waiting: nothing may pop or retire.
    push_rand();
    rst_r = 1'b1;
    run(3);
    rst_r = 1'b0;
    run(STAGES + 3);

    // Directed arithmetic corners.
    push_op(MUL_OP_MUL, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b1, 32'hFFFF_FFFE);
    run(STAGES + 2);
    push_op(MUL_OP_MULH, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h4000_0000);
    push_op(MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFE);
    push_op(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF);
    run(STAGES + 4);

    // Eight back-to-back ops must retire as eight consecutive writes.
    we_cnt = 0;
    for (int i = 0; i < 8; i++) push_rand();
    run(8 + STAGES + 3);
    check_eq("b2b_we_count", 64'(we_cnt), 64'(8));
    check_eq("b2b_we_span", 64'(we_last - we_first + 1), 64'(8));

    // Back-pressure with three ops in flight and a fourth waiting.
    for (int i = 0; i < 4; i++) push_rand();
    run(3);
    full_r = 1'b1;
    we_cnt = 0;
    run(4);
    check_eq("stall_no_we", 64'(we_cnt), 64'(0));
    full_r = 1'b0;
    run(STAGES + 4);
    check_eq("stall_drain_count", 64'(we_cnt), 64'(4));

    // Flush with three ops in flight and a valid FIFO head.
    for (int i = 0; i < 4; i++) push_rand();
    run(3);
    cen_r   = 1'b1;
    flush_r = 1'b1;
    run(1);
    cen_r   = 1'b0;
    flush_r = 1'b0;
    we_cnt  = 0;
    run(STAGES + 3);
    check_eq("post_flush_we_count", 64'(we_cnt), 64'(1));

    // Exception op still retires, with zero result and no wakeup.
    push_op(MUL_OP_MULH, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, 32'h0);
    run(STAGES + 2);

    // Randomised traffic: back-pressure, flushes, commit packets without flush.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) push_rand();
      full_r  = ($urandom_range(0, 3) == 0);
      cen_r   = ($urandom_range(0, 7) == 0);
      flush_r = ($urandom_range(0, 3) == 0);
      step();
    end
    full_r  = 1'b0;
    cen_r   = 1'b0;
    flush_r = 1'b0;
    run(src_q.size() + STAGES + 3);

    // Reset in the middle of a stream drops everything in flight.
    for (int i = 0; i < 5; i++) push_rand();
    run(2);
    rst_r  = 1'b1;
    we_cnt = 0;
    run(2);
    rst_r  = 1'b0;
    run(1);
    check_eq("rst_no_we", 64'(we_cnt), 64'(0));
    run(src_q.size() + STAGES + 4);
    check_eq("drained_src", 64'(src_q.size()), 64'(0));
    check_eq("drained_fly", 64'(fly_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
